muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M/RV64M multiply-divide unit parametrised in XLEN. It executes the eight M-extension funct3 operations behind a valid/ready handshake, alongside the single-cycle ALU in the execute stage. It takes XLEN+2 cycles per operation, or one cycle for divide-by-zero and signed-overflow fast paths. Integer ALU decoding is unchanged; the control unit routes instructions with funct7 == 7'b0000001 here.

## Interface
- XLEN, 32: operand/result width; legal values 32, 64.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; single clock domain.
- flush  in  1  synchronous abort of the in-flight operation.
- start_valid  in  1  operands/funct3 valid.
- start_ready  out  1  unit can accept; high only in IDLE.
- funct3  in  3  M-extension operation select.
- op_a  in  XLEN  rs1 value.
- op_b  in  XLEN  rs2 value.
- result  out  XLEN  operation result; valid while result_valid.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.
- busy  out  1  high in CALC, FIX or DONE.

## Operation
- funct3 map:
  - 000 MUL: low XLEN bits.
  - 001 MULH: high bits, signed×signed.
  - 010 MULHSU: high bits, signed×unsigned.
  - 011 MULHU: high bits, unsigned×unsigned.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Accept when start_valid && start_ready. Latch funct3, the operand signs, and the operand magnitudes; an operand is negated only when it is signed for that op and its MSB is 1.
- States:
  - IDLE: on accept, go to CALC, or to DONE when a special case applies.
  - CALC: XLEN iterations, then FIX.
  - FIX: one cycle, then DONE.
  - DONE: result_valid=1; on result_ready, go to IDLE.
- Multiply: radix-2 shift-add into a 2·XLEN accumulator, one multiplier bit per cycle, LSB first.
- Divide: radix-2 restoring division, one quotient bit per cycle, MSB first. Partial remainder is XLEN+1 bits.
- FIX:
  - Negate the product when the operand signs differ.
  - Negate the quotient when dividend and divisor signs differ.
  - Give the remainder the sign of the dividend.
  - Select the low or high product half, the quotient, or the remainder.
- Special cases, decided in IDLE on accept and going straight to DONE:
  - op_b == 0, DIV/DIVU: result all ones.
  - op_b == 0, REM/REMU: result op_a.
  - DIV with op_a == 2^(XLEN-1), op_b == all ones: result op_a.
  - REM with the same operands: result 0.
- All arithmetic is modulo 2^XLEN on the output. Intermediate widths must not truncate.
- flush: any state goes to IDLE on the next edge and the result is discarded. flush together with start_valid in IDLE does not accept.
- reset overrides flush and the handshake.

## Timing
- Reset values: state=IDLE, start_ready=1, result_valid=0, busy=0, result=0.
- Normal latency: accept at edge E0; result_valid is high after edge E0+XLEN+2 (34 cycles for XLEN=32).
- Special-case latency: result_valid is high after edge E0+1.
- result and result_valid stay stable until result_ready is sampled high. result_valid drops on that edge.
- start_ready rises the cycle after the result handshake. There are no back-to-back accepts in DONE.
- start_ready and result_valid are registered outputs, with no combinational path from inputs.
- Inputs are sampled only on the accept edge. op_a/op_b may change afterwards.

## Structure
- muldiv_pkg holds:
  - typedef enum for the eight funct3 ops (MD_MUL … MD_REMU).
  - typedef enum logic [1:0] for states: IDLE, CALC, FIX, DONE.
  - FUNCT7_MULDIV = 7'b0000001.
- One natural sub-module: muldiv_special_case. It is combinational and computes the fast-path hit and its result from funct3/op_a/op_b.
- Iteration counter width is $clog2(XLEN)+1.

## Test plan
- MUL 7 × 0xFFFFFFFD -> 0xFFFFFFEB, result_valid exactly 34 cycles after accept.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF. DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
- Fast paths, each with result_valid one cycle after accept:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5%0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Backpressure: hold result_ready low for 5 cycles in DONE. result is stable, start_ready=0, a start_valid pulse is ignored, and the handshake then gives start_ready=1 the next cycle.
- flush asserted 10 cycles into CALC: no result_valid, IDLE next cycle, and a following MUL 3×4 -> 12. Repeat with reset instead of flush: outputs return to reset values.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } md_state_e;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // rs1 is treated as two's complement for these ops
  function automatic logic op_a_signed(input md_op_e op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  // rs2 is treated as two's complement for these ops
  function automatic logic op_b_signed(input md_op_e op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

  function automatic logic op_is_div(input md_op_e op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

endpackage

// File: rtl/muldiv_special_case.sv
// Combinational detection of divide-by-zero and signed-overflow fast paths.
module muldiv_special_case
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            hit_c,
  output logic [XLEN-1:0] value_c
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic b_zero;
  logic ovf;

  assign b_zero = (op_b_i == '0);
  assign ovf    = (op_a_i == MIN_NEG) && (op_b_i == '1);

  // Fast-path hit and its architectural result
  always_comb begin
    hit_c   = 1'b0;
    value_c = '0;
    case (md_op_e'(funct3_i))
      MD_DIV: begin
        if (b_zero) begin
          hit_c   = 1'b1;
          value_c = '1;
        end else if (ovf) begin
          hit_c   = 1'b1;
          value_c = op_a_i;
        end
      end
      MD_DIVU: begin
        if (b_zero) begin
          hit_c   = 1'b1;
          value_c = '1;
        end
      end
      MD_REM: begin
        if (b_zero) begin
          hit_c   = 1'b1;
          value_c = op_a_i;
        end else if (ovf) begin
          hit_c   = 1'b1;
          value_c = '0;
        end
      end
      MD_REMU: begin
        if (b_zero) begin
          hit_c   = 1'b1;
          value_c = op_a_i;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply-divide unit: shift-add multiply, restoring divide.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  input  logic            result_ready,
  output logic            busy
);

  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam int unsigned AW = 2 * XLEN;

  md_state_e       state_q, state_d;
  md_op_e          op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [XLEN-1:0] bmag_q, bmag_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            result_valid_q, result_valid_d;
  logic            start_ready_q, start_ready_d;
  logic            busy_q, busy_d;

  md_op_e          in_op;
  logic            in_neg_a, in_neg_b;
  logic [XLEN-1:0] in_mag_a, in_mag_b;
  logic            sc_hit;
  logic [XLEN-1:0] sc_value;
  logic            accept;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift, div_diff;
  logic [AW-1:0]   prod;
  logic [XLEN-1:0] quo, remv;

  muldiv_special_case #(.XLEN(XLEN)) u_special (
    .funct3_i (funct3),
    .op_a_i   (op_a),
    .op_b_i   (op_b),
    .hit_c    (sc_hit),
    .value_c  (sc_value)
  );

  assign in_op    = md_op_e'(funct3);
  assign in_neg_a = op_a_signed(in_op) && op_a[XLEN-1];
  assign in_neg_b = op_b_signed(in_op) && op_b[XLEN-1];
  assign in_mag_a = in_neg_a ? -op_a : op_a;
  assign in_mag_b = in_neg_b ? -op_b : op_b;
  assign accept   = start_valid && start_ready_q && !flush;

  // Multiply step: add multiplicand into the high half when the multiplier LSB is set
  assign mul_sum = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, bmag_q} : '0);

  // Divide step: trial remainder is XLEN+1 bits; the restored remainder always fits XLEN
  assign div_shift = {rem_q, acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, bmag_q};

  // Sign correction applied in FIX
  assign prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
  assign quo  = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign remv = neg_a_q ? -rem_q : rem_q;

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    bmag_d   = bmag_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = in_op;
          neg_a_d = in_neg_a;
          neg_b_d = in_neg_b;
          bmag_d  = in_mag_b;
          acc_d   = {{XLEN{1'b0}}, in_mag_a};
          rem_d   = '0;
          cnt_d   = '0;
          if (sc_hit) begin
            result_d = sc_value;
            state_d  = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // XLEN iterations, then one settle cycle before sign fix-up
        if (cnt_q == CW'(XLEN)) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (op_is_div(op_q)) begin
            acc_d[XLEN-1:0] = {acc_q[XLEN-2:0], ~div_diff[XLEN]};
            rem_d = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
          end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
          end
        end
      end
      FIX: begin
        case (op_q)
          MD_MUL:                       result_d = prod[XLEN-1:0];
          MD_MULH, MD_MULHSU, MD_MULHU: result_d = prod[AW-1:XLEN];
          MD_DIV, MD_DIVU:              result_d = quo;
          default:                      result_d = remv;
        endcase
        state_d = DONE;
      end
      DONE: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) state_d = IDLE;

    start_ready_d  = (state_d == IDLE);
    result_valid_d = (state_d == DONE);
    busy_d         = (state_d != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      op_q           <= MD_MUL;
      cnt_q          <= '0;
      neg_a_q        <= 1'b0;
      neg_b_q        <= 1'b0;
      bmag_q         <= '0;
      acc_q          <= '0;
      rem_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      start_ready_q  <= 1'b1;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      cnt_q          <= cnt_d;
      neg_a_q        <= neg_a_d;
      neg_b_q        <= neg_b_d;
      bmag_q         <= bmag_d;
      acc_q          <= acc_d;
      rem_q          <= rem_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      start_ready_q  <= start_ready_d;
      busy_q         <= busy_d;
    end
  end

  assign start_ready  = start_ready_q;
  assign result_valid = result_valid_q;
  assign result       = result_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (XLEN=32).
module tb_muldiv_unit;

  localparam int unsigned XLEN = 32;
  localparam int NORM_LAT = XLEN + 2;

  logic            clk = 1'b0;
  logic            reset, flush, start_valid, result_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a, op_b;
  logic            start_ready, result_valid, busy;
  logic [XLEN-1:0] result;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] last_exp;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .funct3       (funct3),
    .op_a         (op_a),
    .op_b         (op_b),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference RV32M semantics
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    logic ovf;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return 32'(ia / ib);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(ia % ib);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic logic is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return (f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check("start_ready_before_accept", 64'(start_ready), 64'd1);
    start_valid = 1'b1;
    funct3 = f;
    op_a = a;
    op_b = b;
    exp_q.push_back(model(f, a, b));
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    funct3 = 3'($urandom_range(0, 7));
    op_a = $urandom;
    op_b = $urandom;
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!result_valid && lat < 200);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    last_exp = exp_q.pop_front();
    if (result_valid) check(tag, 64'(result), 64'(last_exp));
  endtask

  task automatic handshake(input string tag);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    @(negedge clk);
    check({tag, "_valid_drop"}, 64'(result_valid), 64'd0);
    check({tag, "_ready_rise"}, 64'(start_ready), 64'd1);
    check({tag, "_busy_clear"}, 64'(busy), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    start_op(f, a, b);
    wait_result(tag, is_fast(f, a, b) ? 1 : NORM_LAT);
    handshake(tag);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_start_ready"}, 64'(start_ready), 64'd1);
    check({tag, "_result_valid"}, 64'(result_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_result"}, 64'(result), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    start_valid = 1'b0;
    result_ready = 1'b0;
    funct3 = 3'd0;
    op_a = '0;
    op_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    // Directed cases
    run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD);
    run_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    run_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2);
    run_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2);
    run_op("divu",   3'd5, 32'hFFFF_FFF9,  32'd2);
    run_op("divu_z", 3'd5, 32'd5,          32'd0);
    run_op("remu_z", 3'd7, 32'd5,          32'd0);
    run_op("div_ov", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF);
    run_op("rem_ov", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF);
    run_op("div_z",  3'd4, 32'hFFFF_FFF0,  32'd0);
    run_op("rem_z",  3'd6, 32'hFFFF_FFF0,  32'd0);

    // Randomised ops with occasional forced fast-path operands
    for (int i = 0; i < 16; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if (i % 4 == 0) b = 32'd0;
      if (i % 5 == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (i % 6 == 2) b = 32'($urandom_range(1, 15));
      run_op("rand", f, a, b);
    end

    // Backpressure in DONE with an ignored start pulse
    start_op(3'd0, 32'h1234_5678, 32'd9);
    wait_result("bp", NORM_LAT);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        start_valid = 1'b1;
        funct3 = 3'd5;
        op_a = 32'd5;
        op_b = 32'd0;
      end
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      @(negedge clk);
      check("bp_result_stable", 64'(result), 64'(last_exp));
      check("bp_valid_held", 64'(result_valid), 64'd1);
      check("bp_start_ready_low", 64'(start_ready), 64'd0);
    end
    handshake("bp");
    repeat (3) begin
      @(negedge clk);
      check("bp_no_accept", 64'({busy, result_valid}), 64'd0);
    end

    // Flush ten cycles into CALC
    start_op(3'd0, 32'hDEAD_BEEF, 32'h0000_1234);
    void'(exp_q.pop_front());
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("flush_no_valid_calc", 64'(result_valid), 64'd0);
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_idle_ready", 64'(start_ready), 64'd1);
    check("flush_idle_busy", 64'(busy), 64'd0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (result_valid) check("flush_discard", 64'(result_valid), 64'd0);
    end
    check("flush_quiet", 64'(result_valid), 64'd0);

    // flush with start_valid in IDLE must not accept
    @(negedge clk);
    flush = 1'b1;
    start_valid = 1'b1;
    funct3 = 3'd5;
    op_a = 32'd5;
    op_b = 32'd0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    start_valid = 1'b0;
    @(negedge clk);
    check("flush_start_no_accept", 64'({busy, result_valid, start_ready}), 64'b001);
    run_op("mul_after_flush", 3'd0, 32'd3, 32'd4);

    // Reset ten cycles into CALC
    start_op(3'd6, 32'hFFFF_0000, 32'd7);
    void'(exp_q.pop_front());
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("mid_reset");
    run_op("mul_after_reset", 3'd0, 32'd3, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
